// File: rtl/memory_writeback_stage.sv
// Memory-access / write-back stage: one load or store through a ready
// handshake, then a single-cycle register-file write and a done pulse.
module memory_writeback_stage #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en_memory,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           store_data,
    input  logic [4:0]            rd,
    input  logic                  sig_enable_data_memory_read,
    input  logic                  sig_enable_data_memory_write,
    input  logic                  sig_write_back_data_select,
    input  logic                  sig_rf_enable_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  mem_read_req,
    output logic                  mem_write_req,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_read_data,
    output logic [31:0]           BusW,
    output logic [4:0]            RW,
    output logic                  rf_write_enable,
    output logic                  busy,
    output logic                  stage_done,
    output logic                  mem_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WB     = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [31:0]           r_alu;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_mdata;
    logic [4:0]            r_rd;
    logic                  r_ld;
    logic                  r_sel;
    logic                  r_rf_we;
    logic                  r_read_req;
    logic                  r_write_req;
    logic [31:0]           r_busw;
    logic [4:0]            r_rw;
    logic                  r_rf_wr;
    logic                  r_done;
    logic                  r_err;

    logic        w_mem_op;
    logic        w_bad;
    logic [31:0] w_mdata;

    assign w_mem_op = sig_enable_data_memory_read | sig_enable_data_memory_write;
    assign w_bad = (sig_enable_data_memory_read & sig_enable_data_memory_write)
                 | (w_mem_op & (alu_result[1:0] != 2'b00));
    assign w_mdata = r_ld ? mem_read_data : r_mdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_alu       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mdata     <= '0;
            r_rd        <= '0;
            r_ld        <= 1'b0;
            r_sel       <= 1'b0;
            r_rf_we     <= 1'b0;
            r_read_req  <= 1'b0;
            r_write_req <= 1'b0;
            r_busw      <= '0;
            r_rw        <= '0;
            r_rf_wr     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // pulses last exactly one cycle unless re-armed below
            r_done  <= 1'b0;
            r_rf_wr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en_memory) begin
                        r_alu   <= alu_result;
                        r_addr  <= alu_result[ADDR_WIDTH-1:0];
                        r_wdata <= store_data;
                        r_rd    <= rd;
                        r_ld    <= sig_enable_data_memory_read;
                        r_sel   <= sig_write_back_data_select;
                        r_rf_we <= sig_rf_enable_write;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        if (w_bad) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                        end else if (w_mem_op) begin
                            r_state     <= S_ACCESS;
                            r_read_req  <= sig_enable_data_memory_read;
                            r_write_req <= sig_enable_data_memory_write;
                        end else begin
                            r_state <= S_WB;
                            r_busw  <= sig_write_back_data_select ? r_mdata
                                                                  : alu_result;
                            r_rw    <= rd;
                            r_rf_wr <= sig_rf_enable_write & (rd != 5'd0);
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_ready) begin
                        r_state     <= S_WB;
                        r_read_req  <= 1'b0;
                        r_write_req <= 1'b0;
                        r_mdata     <= w_mdata;
                        r_busw      <= r_sel ? w_mdata : r_alu;
                        r_rw        <= r_rd;
                        r_rf_wr     <= r_rf_we & (r_rd != 5'd0);
                        r_done      <= 1'b1;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= S_ERR;
                        r_read_req  <= 1'b0;
                        r_write_req <= 1'b0;
                        r_err       <= 1'b1;
                        r_done      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_address     = r_addr;
    assign mem_write_data  = r_wdata;
    assign mem_read_req    = r_read_req;
    assign mem_write_req   = r_write_req;
    assign BusW            = r_busw;
    assign RW              = r_rw;
    assign rf_write_enable = r_rf_wr;
    assign busy            = (r_state != S_IDLE);
    assign stage_done      = r_done;
    assign mem_error       = r_err;

endmodule
